// File: rtl/iir_bank.sv
// iir_bank: time-multiplexed first-order IIR filter bank.
// One shared multiplier serves NUM_CH channels. Each accepted sample is run
// through every channel in turn:
//   y[n] = sat_W((b0*x[n] + b1*x[n-1] + a1*y[n-1]) >>> FRAC)
// Coefficients can be loaded per channel at run time while the engine is idle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   clr                       synchronous clear of filter state and FSM (coefficients kept)
//   in_valid/in_ready/in_data sample input handshake (in_ready = engine idle)
//   cfg_we/cfg_ch/cfg_sel/cfg_data  coefficient write (sel 0=b0, 1=b1, 2=a1, 3=ignored)
//   cfg_err                   one-cycle pulse: write rejected because engine was busy
//   out_valid/out_ch/out_data/out_sat  per-channel result, one-cycle pulse, no backpressure
module iir_bank #(
   parameter int unsigned W      = 16,
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned FRAC   = 8,
   parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        in_data,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_sel,
   input  logic [W-1:0]        cfg_data,
   output logic                cfg_err,
   output logic                out_valid,
   output logic [CH_W-1:0]     out_ch,
   output logic [W-1:0]        out_data,
   output logic                out_sat
);

   localparam int unsigned PROD_W = 2 * W;
   localparam int unsigned ACC_W  = 2 * W + 2;

   // Saturation bounds expressed in accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [W-1:0]            MAX_W  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]            MIN_W  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, WB} state_t;

   state_t                   state, state_n;
   logic [CH_W-1:0]          ch;
   logic signed [W-1:0]      xr;
   logic signed [W-1:0]      b0 [NUM_CH];
   logic signed [W-1:0]      b1 [NUM_CH];
   logic signed [W-1:0]      a1 [NUM_CH];
   logic signed [W-1:0]      x1 [NUM_CH];
   logic signed [W-1:0]      y1 [NUM_CH];
   logic signed [ACC_W-1:0]  acc;

   logic                     last_ch_c;
   logic                     cfg_ok_c;
   logic signed [W-1:0]      mul_a_c, mul_b_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  shifted_c;
   logic                     sat_hi_c, sat_lo_c;
   logic [W-1:0]             y_sat_c;

   assign last_ch_c = (ch == CH_W'(NUM_CH - 1));
   // Writes to the reserved select or a non-existent channel are silently dropped.
   assign cfg_ok_c  = (cfg_sel != 2'd3) && (32'(cfg_ch) < NUM_CH);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Next-state logic; clr overrides everything, including a same-cycle handshake
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid) state_n = MAC0;
         MAC0:    state_n = MAC1;
         MAC1:    state_n = MAC2;
         MAC2:    state_n = WB;
         WB:      state_n = last_ch_c ? IDLE : MAC0;
         default: state_n = IDLE;
      endcase
      if (clr) state_n = IDLE;
   end

   // Shared multiplier operand select: one product per MAC state
   always_comb begin
      mul_a_c = '0;
      mul_b_c = '0;
      case (state)
         MAC0: begin mul_a_c = b0[ch]; mul_b_c = xr;     end
         MAC1: begin mul_a_c = b1[ch]; mul_b_c = x1[ch]; end
         MAC2: begin mul_a_c = a1[ch]; mul_b_c = y1[ch]; end
         default: ;
      endcase
   end

   assign prod_c = mul_a_c * mul_b_c;

   // Arithmetic shift (floor) followed by clamp to the W-bit signed range
   always_comb begin
      shifted_c = acc >>> FRAC;
      sat_hi_c  = (shifted_c > SAT_HI);
      sat_lo_c  = (shifted_c < SAT_LO);
      if (sat_hi_c)      y_sat_c = MAX_W;
      else if (sat_lo_c) y_sat_c = MIN_W;
      else               y_sat_c = shifted_c[W-1:0];
   end

   // Datapath, coefficient store, per-channel state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch        <= '0;
         xr        <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         cfg_err   <= 1'b0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            b0[i] <= '0;
            b1[i] <= '0;
            a1[i] <= '0;
            x1[i] <= '0;
            y1[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         cfg_err   <= 1'b0;
         in_ready  <= (state_n == IDLE);

         if (cfg_we && cfg_ok_c) begin
            if (state == IDLE) begin
               case (cfg_sel)
                  2'd0:    b0[cfg_ch] <= cfg_data;
                  2'd1:    b1[cfg_ch] <= cfg_data;
                  2'd2:    a1[cfg_ch] <= cfg_data;
                  default: ;
               endcase
            end else begin
               cfg_err <= 1'b1;
            end
         end

         case (state)
            IDLE: if (in_valid) begin
               xr <= in_data;
               ch <= '0;
            end
            MAC0: acc <= ACC_W'(prod_c);
            MAC1: acc <= acc + ACC_W'(prod_c);
            MAC2: acc <= acc + ACC_W'(prod_c);
            WB: begin
               if (!clr) begin
                  out_valid <= 1'b1;
                  out_ch    <= ch;
                  out_data  <= y_sat_c;
                  out_sat   <= sat_hi_c | sat_lo_c;
               end
               x1[ch] <= xr;
               y1[ch] <= y_sat_c;
               if (!last_ch_c) ch <= ch + CH_W'(1);
            end
            default: ;
         endcase

         // Clear wins over the writeback above.
         if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
               x1[i] <= '0;
               y1[i] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_iir_bank.sv
// Testbench for iir_bank: directed steps plus randomized samples/coefficients,
// checked against an arithmetic reference model of the filter equations.
module tb_iir_bank;

   localparam int unsigned W    = 16;
   localparam int unsigned NCH  = 2;
   localparam int unsigned FRAC = 8;
   localparam int unsigned CH_W = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            clr;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic            cfg_we;
   logic [CH_W-1:0] cfg_ch;
   logic [1:0]      cfg_sel;
   logic [W-1:0]    cfg_data;
   logic            cfg_err;
   logic            out_valid;
   logic [CH_W-1:0] out_ch;
   logic [W-1:0]    out_data;
   logic            out_sat;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int mb0 [NCH];
   int mb1 [NCH];
   int ma1 [NCH];
   int mx1 [NCH];
   int my1 [NCH];

   iir_bank #(.W(W), .NUM_CH(NCH), .FRAC(FRAC), .CH_W(CH_W)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .cfg_err(cfg_err),
      .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dout();
      return int'($signed(out_data));
   endfunction

   function automatic void model_reset(input bit coefs);
      for (int c = 0; c < NCH; c++) begin
         if (coefs) begin
            mb0[c] = 0; mb1[c] = 0; ma1[c] = 0;
         end
         mx1[c] = 0; my1[c] = 0;
      end
   endfunction

   function automatic void model_cfg(input int c, input int sel, input int data);
      if (c < NCH) begin
         if (sel == 0) mb0[c] = data;
         else if (sel == 1) mb1[c] = data;
         else if (sel == 2) ma1[c] = data;
      end
   endfunction

   // Filter equation with plain 64-bit arithmetic, floor shift and clamp.
   function automatic void model_eval(input int c, input int x, output int y, output int s);
      longint v;
      v = longint'(mb0[c]) * x + longint'(mb1[c]) * mx1[c] + longint'(ma1[c]) * my1[c];
      v = v >>> FRAC;
      s = 0;
      if (v > 32767) begin v = 32767; s = 1; end
      else if (v < -32768) begin v = -32768; s = 1; end
      y = int'(v);
   endfunction

   task automatic do_cfg(input int c, input int sel, input int data);
      cfg_we   = 1'b1;
      cfg_ch   = CH_W'(c);
      cfg_sel  = 2'(sel);
      cfg_data = W'(data);
      tick();
      cfg_we = 1'b0;
      check("cfg_err idle", int'(cfg_err), 0);
      model_cfg(c, sel, data);
   endtask

   task automatic clr_idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_reset(1'b0);
      check("clr idle ready", int'(in_ready), 1);
   endtask

   // One sample through all channels. busy_cfg_edge/clr_edge: edge (1..4*NCH)
   // at which a busy cfg write or a clr is sampled; 0 disables. cfg0 writes a
   // coefficient in the same cycle as the handshake.
   task automatic send_sample(input int x, input int busy_cfg_edge, input int clr_edge,
                              input bit cfg0, input int cc, input int cs, input int cd,
                              output int y0);
      int ey [NCH];
      int es [NCH];
      int last_e;
      y0 = 32'h7fff_ffff;
      last_e = 4 * NCH;
      check("ready before sample", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = W'(x);
      if (cfg0) begin
         cfg_we = 1'b1; cfg_ch = CH_W'(cc); cfg_sel = 2'(cs); cfg_data = W'(cd);
         model_cfg(cc, cs, cd);
      end
      for (int c = 0; c < NCH; c++) model_eval(c, x, ey[c], es[c]);
      tick();
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      check("ready low e0", int'(in_ready), 0);
      for (int e = 1; e <= last_e; e++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = W'($urandom);
         if (e == busy_cfg_edge) begin
            cfg_we = 1'b1; cfg_ch = '0; cfg_sel = 2'd0; cfg_data = W'(999);
         end
         if (e == clr_edge) clr = 1'b1;
         tick();
         cfg_we   = 1'b0;
         clr      = 1'b0;
         in_valid = 1'b0;
         if (e == clr_edge) begin
            check("clr ready", int'(in_ready), 1);
            check("clr no valid", int'(out_valid), 0);
            model_reset(1'b0);
            for (int k = 0; k < last_e; k++) begin
               tick();
               check("after clr no valid", int'(out_valid), 0);
            end
            return;
         end
         check("cfg_err busy", int'(cfg_err), (e == busy_cfg_edge) ? 1 : 0);
         check("ready timing", int'(in_ready), (e == last_e) ? 1 : 0);
         check("out_valid timing", int'(out_valid), (e % 4 == 0) ? 1 : 0);
         if (out_valid && (e % 4 == 0)) begin
            check("out_ch", int'(out_ch), e / 4 - 1);
            check("out_data", dout(), ey[e/4-1]);
            check("out_sat", int'(out_sat), es[e/4-1]);
            if (e == 4) y0 = dout();
         end
      end
      for (int c = 0; c < NCH; c++) begin
         mx1[c] = x;
         my1[c] = ey[c];
      end
   endtask

   task automatic sample(input int x, output int y0);
      send_sample(x, 0, 0, 1'b0, 0, 0, 0, y0);
   endtask

   function automatic int rnd_s16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   initial begin
      int y;
      int ce;
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
      model_reset(1'b1);
      repeat (3) tick();
      check("rst out_valid", int'(out_valid), 0);
      check("rst out_data", dout(), 0);
      check("rst cfg_err", int'(cfg_err), 0);
      rst = 1'b1;
      tick();
      check("post-rst ready", int'(in_ready), 1);

      // Reset asserted in the middle of a sample clears coefficients too.
      do_cfg(0, 0, 256);
      do_cfg(1, 1, 77);
      in_valid = 1'b1; in_data = W'(5);
      tick();
      in_valid = 1'b0;
      tick(); tick();
      #2 rst = 1'b0;
      #1;
      check("async rst out_valid", int'(out_valid), 0);
      check("async rst cfg_err", int'(cfg_err), 0);
      tick();
      rst = 1'b1;
      model_reset(1'b1);
      tick();
      check("rst2 ready", int'(in_ready), 1);
      check("rst2 out_valid", int'(out_valid), 0);
      check("rst2 out_data", dout(), 0);
      check("rst2 out_ch", int'(out_ch), 0);
      check("rst2 out_sat", int'(out_sat), 0);
      sample(1234, y);
      check("default coef ch0", y, 0);

      // Pass-through, +1.0 on ch0 and -1.0 on ch1
      do_cfg(0, 0, 256);
      do_cfg(1, 0, -256);
      sample(1000, y);
      check("passthru ch0", y, 1000);

      // Low-pass recursion
      clr_idle();
      do_cfg(0, 0, 3); do_cfg(0, 1, 3); do_cfg(0, 2, 250);
      sample(1000, y);
      check("lp first", y, 11);
      sample(1000, y);
      check("lp second", y, 34);

      // clr mid-sample, then state restarts from zero with coefficients kept
      send_sample(1000, 0, 6, 1'b0, 0, 0, 0, y);
      sample(1000, y);
      check("lp after clr", y, 11);

      // Negative input floors toward minus infinity
      do_cfg(0, 0, 1); do_cfg(0, 1, 0); do_cfg(0, 2, 0);
      sample(-1, y);
      check("floor neg", y, -1);

      // Saturation both ways; clamped value feeds back
      do_cfg(0, 0, 32767);
      sample(1000, y);
      check("sat hi", y, 32767);
      sample(-1000, y);
      check("sat lo", y, -32768);
      do_cfg(0, 0, 0); do_cfg(0, 2, 128);
      sample(0, y);
      check("clamped feedback", y, -16384);

      // Config rules
      send_sample(50, 2, 0, 1'b0, 0, 0, 0, y);
      sample(50, y);
      do_cfg(0, 3, 1234);
      send_sample(100, 0, 0, 1'b1, 1, 0, 512, y);

      // Randomized coefficients and samples
      for (int it = 0; it < 40; it++) begin
         int n;
         n = int'($urandom_range(0, 2));
         for (int k = 0; k < n; k++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? rnd_s16() : int'($urandom_range(0, 1023)) - 512;
            do_cfg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)), d);
         end
         ce = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4 * NCH)) : 0;
         send_sample(rnd_s16(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * NCH)) : 0,
                     ce, 1'($urandom_range(0, 1)), int'($urandom_range(0, NCH - 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 511)) - 256, y);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
